// File: rtl/rfphoenix_branch_resolve.sv
// Branch resolution stage: registers the evaluated branch, detects mispredictions, and drives the
// fetch redirect, the flush pulse, the predictor update and the performance counters.
module rfphoenix_branch_resolve #(
    parameter int unsigned AWID       = 32,
    parameter int unsigned TIDW       = 2,
    parameter int unsigned INSN_BYTES = 5,
    parameter int unsigned CNTW       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [TIDW-1:0] tid_i,
    input  logic [AWID-1:0] pc_i,
    input  logic [AWID-1:0] target_i,
    input  logic            pred_taken_i,
    input  logic            takb_i,
    output logic            redirect_v_o,
    output logic [TIDW-1:0] redirect_tid_o,
    output logic [AWID-1:0] redirect_pc_o,
    input  logic            redirect_ack_i,
    output logic            flush_o,
    output logic [TIDW-1:0] flush_tid_o,
    output logic            bpu_v_o,
    output logic [TIDW-1:0] bpu_tid_o,
    output logic [AWID-1:0] bpu_pc_o,
    output logic            bpu_taken_o,
    output logic [CNTW-1:0] br_cnt_o,
    output logic [CNTW-1:0] mis_cnt_o
);

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e          state_q, state_d;
    logic [TIDW-1:0] redirect_tid_q;
    logic [AWID-1:0] redirect_pc_q;
    logic            flush_q;
    logic [TIDW-1:0] flush_tid_q;
    logic            bpu_v_q;
    logic [TIDW-1:0] bpu_tid_q;
    logic [AWID-1:0] bpu_pc_q;
    logic            bpu_taken_q;
    logic [CNTW-1:0] br_cnt_q, br_cnt_d;
    logic [CNTW-1:0] mis_cnt_q, mis_cnt_d;

    logic            xfer;
    logic            mis_xfer;
    logic [AWID-1:0] correct_pc;

    // An ack frees the slot in the same cycle, so a new branch can ride along with it.
    assign ready_o    = (state_q == StIdle) | redirect_ack_i;
    assign xfer       = valid_i & ready_o;
    assign mis_xfer   = xfer & (takb_i ^ pred_taken_i);
    assign correct_pc = takb_i ? target_i : pc_i + AWID'(INSN_BYTES);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mis_xfer) state_d = StRedirect;
            end
            StRedirect: begin
                if (mis_xfer)            state_d = StRedirect;
                else if (redirect_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (xfer && (br_cnt_q != '1))      br_cnt_d  = br_cnt_q + CNTW'(1);
        if (mis_xfer && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            redirect_tid_q <= '0;
            redirect_pc_q  <= '0;
            flush_q        <= 1'b0;
            flush_tid_q    <= '0;
            bpu_v_q        <= 1'b0;
            bpu_tid_q      <= '0;
            bpu_pc_q       <= '0;
            bpu_taken_q    <= 1'b0;
            br_cnt_q       <= '0;
            mis_cnt_q      <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= mis_xfer;
            bpu_v_q   <= xfer;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (xfer) begin
                bpu_tid_q   <= tid_i;
                bpu_pc_q    <= pc_i;
                bpu_taken_q <= takb_i;
            end
            // Only mispredicts touch the redirect target, keeping it stable while it is held.
            if (mis_xfer) begin
                redirect_tid_q <= tid_i;
                redirect_pc_q  <= correct_pc;
                flush_tid_q    <= tid_i;
            end
        end
    end

    assign redirect_v_o   = (state_q == StRedirect);
    assign redirect_tid_o = redirect_tid_q;
    assign redirect_pc_o  = redirect_pc_q;
    assign flush_o        = flush_q;
    assign flush_tid_o    = flush_tid_q;
    assign bpu_v_o        = bpu_v_q;
    assign bpu_tid_o      = bpu_tid_q;
    assign bpu_pc_o       = bpu_pc_q;
    assign bpu_taken_o    = bpu_taken_q;
    assign br_cnt_o       = br_cnt_q;
    assign mis_cnt_o      = mis_cnt_q;

endmodule

// File: tb/tb_rfphoenix_branch_resolve.sv
// Bench for rfphoenix_branch_resolve: directed cases then random traffic, checked against a
// transaction-level model; a second instance with 4-bit counters exercises saturation.
module tb_rfphoenix_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [1:0]  tid_i;
    logic [31:0] pc_i;
    logic [31:0] target_i;
    logic        pred_taken_i;
    logic        takb_i;
    logic        redirect_ack_i;

    logic        ready_o, redirect_v_o, flush_o, bpu_v_o, bpu_taken_o;
    logic [1:0]  redirect_tid_o, flush_tid_o, bpu_tid_o;
    logic [31:0] redirect_pc_o, bpu_pc_o, br_cnt_o, mis_cnt_o;

    logic        ready4, redirect_v4, flush4, bpu_v4, bpu_taken4;
    logic [1:0]  redirect_tid4, flush_tid4, bpu_tid4;
    logic [31:0] redirect_pc4, bpu_pc4;
    logic [3:0]  br_cnt4, mis_cnt4;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    bit          m_pend;
    logic [1:0]  m_rtid, m_ftid, m_btid;
    logic [31:0] m_rpc, m_bpc;
    bit          m_flush, m_bv, m_btk;
    longint      m_br32, m_mis32, m_br4, m_mis4;

    always #5 clk = ~clk;

    rfphoenix_branch_resolve #(.AWID(32), .TIDW(2), .INSN_BYTES(5), .CNTW(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .tid_i(tid_i),
        .pc_i(pc_i), .target_i(target_i), .pred_taken_i(pred_taken_i), .takb_i(takb_i),
        .redirect_v_o(redirect_v_o), .redirect_tid_o(redirect_tid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ack_i(redirect_ack_i), .flush_o(flush_o),
        .flush_tid_o(flush_tid_o), .bpu_v_o(bpu_v_o), .bpu_tid_o(bpu_tid_o),
        .bpu_pc_o(bpu_pc_o), .bpu_taken_o(bpu_taken_o), .br_cnt_o(br_cnt_o),
        .mis_cnt_o(mis_cnt_o)
    );

    rfphoenix_branch_resolve #(.AWID(32), .TIDW(2), .INSN_BYTES(5), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready4), .tid_i(tid_i),
        .pc_i(pc_i), .target_i(target_i), .pred_taken_i(pred_taken_i), .takb_i(takb_i),
        .redirect_v_o(redirect_v4), .redirect_tid_o(redirect_tid4),
        .redirect_pc_o(redirect_pc4), .redirect_ack_i(redirect_ack_i), .flush_o(flush4),
        .flush_tid_o(flush_tid4), .bpu_v_o(bpu_v4), .bpu_tid_o(bpu_tid4),
        .bpu_pc_o(bpu_pc4), .bpu_taken_o(bpu_taken4), .br_cnt_o(br_cnt4),
        .mis_cnt_o(mis_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_rtid = 0; m_rpc = 0; m_flush = 0; m_ftid = 0;
        m_bv = 0; m_btid = 0; m_bpc = 0; m_btk = 0;
        m_br32 = 0; m_mis32 = 0; m_br4 = 0; m_mis4 = 0;
    endtask

    // One clock cycle: drive, check combinational ready, update model, check registered outputs.
    task automatic step(input bit r, input bit v, input logic [1:0] tid, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit pred, input bit tk, input bit ack);
        bit rdy, xf, ms;
        logic [31:0] fall;
        rst = r; valid_i = v; tid_i = tid; pc_i = pc; target_i = tgt;
        pred_taken_i = pred; takb_i = tk; redirect_ack_i = ack;
        #1;
        rdy = !m_pend || ack;
        chk("ready", ready_o, rdy);
        chk("ready4", ready4, rdy);
        if (r) begin
            model_reset();
        end else begin
            xf = v && rdy;
            ms = xf && (pred != tk);
            fall = pc + 32'd5;
            m_bv = xf;
            m_flush = ms;
            if (xf) begin
                m_btid = tid; m_bpc = pc; m_btk = tk;
                if (m_br32 < 64'hFFFF_FFFF) m_br32++;
                if (m_br4 < 15) m_br4++;
            end
            if (ms) begin
                if (m_mis32 < 64'hFFFF_FFFF) m_mis32++;
                if (m_mis4 < 15) m_mis4++;
                m_ftid = tid; m_pend = 1; m_rtid = tid;
                m_rpc = tk ? tgt : fall;
            end else if (ack) begin
                m_pend = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("redirect_v", redirect_v_o, m_pend);
        chk("redirect_tid", redirect_tid_o, m_rtid);
        chk("redirect_pc", redirect_pc_o, m_rpc);
        chk("flush", flush_o, m_flush);
        chk("flush_tid", flush_tid_o, m_ftid);
        chk("bpu_v", bpu_v_o, m_bv);
        chk("bpu_tid", bpu_tid_o, m_btid);
        chk("bpu_pc", bpu_pc_o, m_bpc);
        chk("bpu_taken", bpu_taken_o, m_btk);
        chk("br_cnt", br_cnt_o, m_br32);
        chk("mis_cnt", mis_cnt_o, m_mis32);
        chk("redirect_v4", redirect_v4, m_pend);
        chk("flush4", flush4, m_flush);
        chk("bpu_v4", bpu_v4, m_bv);
        chk("br_cnt4", br_cnt4, m_br4);
        chk("mis_cnt4", mis_cnt4, m_mis4);
    endtask

    initial begin
        rst = 1; valid_i = 0; tid_i = 0; pc_i = 0; target_i = 0;
        pred_taken_i = 0; takb_i = 0; redirect_ack_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // Correct not-taken branch
        step(0, 1, 1, 32'h1000, 32'h1800, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Mispredict taken, held without ack; valid during hold must be ignored
        step(0, 1, 2, 32'h2000, 32'h3000, 0, 1, 0);
        chk("t2_redirect_pc", redirect_pc_o, 32'h3000);
        step(0, 1, 3, 32'h7777, 32'h8888, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Mispredict not-taken with wrapping fall-through
        step(0, 1, 0, 32'hFFFF_FFFE, 32'h1234, 1, 0, 0);
        chk("t3_wrap_pc", redirect_pc_o, 32'h0000_0003);
        // Ack together with a new mispredict reloads the redirect
        step(0, 1, 1, 32'h4000, 32'h5000, 0, 1, 1);
        chk("t4_reload_pc", redirect_pc_o, 32'h5000);
        step(0, 1, 2, 32'h4100, 32'h4200, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Saturation on the 4-bit counters
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(0, 1, 2'(i), 32'h100 * i, 32'h9000 + i, 1, 0, 1);
        chk("t5_br_sat", br_cnt4, 4'hF);
        chk("t5_mis_sat", mis_cnt4, 4'hF);
        // Reset while a redirect is pending
        step(0, 1, 3, 32'h6000, 32'h6100, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 2'($urandom),
                 $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
